reg_mem_burst_ctrl: RTL and testbench
=====================================

REG_MEM_BURST_CTRL -- requirements
Module: reg_mem_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-002 SHALL have parameter ADDR_BITS, default 5, memory address width (2^ADDR_BITS words).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock shared with the register memory.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-007 SHALL have port mode  input  1  0 = write burst, 1 = read burst, sampled with start.
REQ-008 SHALL have port base_addr  input  ADDR_BITS  first burst address, sampled with start.
REQ-009 SHALL have port len  input  ADDR_BITS  burst length minus one (1..2^ADDR_BITS words), sampled with start.
REQ-010 SHALL have ports in_valid (input, 1), in_data (input, DATA_WIDTH) and in_ready (output, 1): upstream write stream.
REQ-011 SHALL have ports out_valid (output, 1), out_data (output, DATA_WIDTH) and out_ready (input, 1): downstream read stream.
REQ-012 SHALL have ports mem_addr (output, ADDR_BITS), mem_din (output, DATA_WIDTH), mem_wen (output, 1) and mem_dout (input, DATA_WIDTH) to the register memory.
REQ-013 SHALL have ports busy (output, 1) high outside IDLE, and done (output, 1) as a one-cycle end-of-burst pulse.

Function
REQ-014 SHALL implement the states IDLE, WR, RD_REQ, RD_CAP, RD_OUT and DONE.
REQ-015 IDLE: on start=1, latch base_addr into the address counter, latch len and clear the word counter; next state is WR if mode=0, else RD_REQ.
REQ-016 WR: in_ready=1, mem_addr=address counter, mem_din=in_data, mem_wen=in_valid (combinational); each accepted word (in_valid&in_ready) is written at that rising edge.
REQ-017 WR: each accepted word increments the address counter modulo 2^ADDR_BITS (wrap 31->0) and the word counter; the word at word count == len moves the FSM to DONE.
REQ-018 WR with in_valid=0: no write, no counter change, stay in WR indefinitely.
REQ-019 Memory read latency is one cycle: mem_dout reflects the mem_addr presented in the previous cycle.
REQ-020 RD_REQ: drive mem_addr=address counter with mem_wen=0; next state RD_CAP.
REQ-021 RD_CAP: register mem_dout into out_data, set out_valid=1; next state RD_OUT.
REQ-022 RD_OUT: hold out_valid and out_data stable until out_ready=1; on the handshake, clear out_valid, increment the address counter (wrap) and the word counter; go to DONE if word count == len, else RD_REQ.
REQ-023 Read throughput is at most one word per 3 cycles; no overlap between words.
REQ-024 DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
REQ-025 start while not in IDLE SHALL be ignored with no side effects.
REQ-026 mem_wen SHALL be 0 in every state except WR; in_ready SHALL be 0 outside WR; out_valid SHALL be 1 only in RD_OUT.
REQ-027 A len of 2^ADDR_BITS-1 SHALL cover every address exactly once, with wrap from base_addr.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counters 0, out_data 0, and out_valid, in_ready, mem_wen, busy and done all 0.
REQ-029 mem_addr and mem_din SHALL be 0 while in IDLE.
REQ-030 Reset mid-burst SHALL abort the burst with no further writes; memory contents already written remain.

Verification
REQ-031 Write burst base=0, len=31, in_data 10..41 with in_valid always 1 -> 32 writes, address i holds 10+i, done pulses one cycle after the last write.
REQ-032 Read burst base=0, len=31, out_ready=1 -> out_data sequence 10..41, one word every 3 cycles, then done.
REQ-033 Write base=30, len=3, data AA,BB,CC,DD -> addresses 30,31,0,1 written; read-back of the same burst returns AA,BB,CC,DD.
REQ-034 Read with out_ready low for 5 cycles on word 2 -> out_valid and out_data held stable, no address advance, correct sequence after release.
REQ-035 Write burst with in_valid gaps, plus start pulsed mid-burst -> writes only on valid cycles, start ignored, exact len+1 words written.
REQ-036 rst asserted after 3 of 8 writes -> outputs zero immediately, busy=0, only 3 addresses modified, new start accepted afterwards.

Source files
------------

// File: rtl/reg_mem_burst_ctrl.sv
// Burst controller for a one-cycle-latency register memory. It writes a stream of words into
// consecutive addresses, or reads them out one word at a time through a valid/ready port.
module reg_mem_burst_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_BITS-1:0]  base_addr,
    input  logic [ADDR_BITS-1:0]  len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {StIdle, StWr, StRdReq, StRdCap, StRdOut, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [ADDR_BITS-1:0]    len_q, len_d;
    logic [ADDR_BITS-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = base_addr;
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = mode ? StRdReq : StWr;
                end
            end
            StWr: begin
                if (in_valid) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == len_q) state_d = StDone;
                end
            end
            StRdReq: state_d = StRdCap;
            StRdCap: begin
                // mem_dout now carries the word addressed during StRdReq
                out_data_d  = mem_dout;
                out_valid_d = 1'b1;
                state_d     = StRdOut;
            end
            StRdOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    addr_d      = addr_q + 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    state_d     = (cnt_q == len_q) ? StDone : StRdReq;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Memory-side and stream-side strobes decode straight from the registered state
    assign in_ready  = (state_q == StWr);
    assign mem_wen   = in_ready & in_valid;
    assign mem_addr  = (state_q == StWr || state_q == StRdReq) ? addr_q : '0;
    assign mem_din   = (state_q == StWr) ? in_data : '0;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_reg_mem_burst_ctrl.sv
// Bench for reg_mem_burst_ctrl: drives directed and random bursts against an attached register
// memory and checks outputs and memory contents against an address-indexed expected image.
module tb_reg_mem_burst_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;
    localparam int unsigned NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, mode, in_valid, out_ready;
    logic [AW-1:0] base_addr, len;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, mem_wen, busy, done;
    logic [DW-1:0] out_data, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem [NW];
    logic [DW-1:0] exp_mem [NW];
    logic [DW-1:0] wdata [NW];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Register memory: synchronous write, one-cycle registered read
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    reg_mem_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_inrdy"}, 32'(in_ready), 0);
        chk({tag, "_wen"}, 32'(mem_wen), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_din"}, 32'(mem_din), 0);
        chk({tag, "_oval"}, 32'(out_valid), 0);
    endtask

    task automatic chk_mem(input string tag);
        for (int a = 0; a < int'(NW); a++) chk($sformatf("%s_mem%0d", tag, a), 32'(mem[a]),
                                              32'(exp_mem[a]));
    endtask

    task automatic fill_random();
        for (int k = 0; k < int'(NW); k++) wdata[k] = DW'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] b, input logic [AW-1:0] l, input bit gaps,
                            input bit pulse);
        int i;
        int cyc;
        bit v;
        logic [AW-1:0] a;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = b; len = l;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        cyc = 0;
        while (i <= int'(l) && cyc < 400) begin
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data = wdata[i];
            if (pulse && $urandom_range(0, 3) == 0) begin
                start = 1'b1; mode = 1'($urandom); base_addr = AW'($urandom); len = AW'($urandom);
            end else begin
                start = 1'b0;
            end
            a = b + AW'(i);
            #1;
            chk("wr_inrdy", 32'(in_ready), 1);
            chk("wr_busy", 32'(busy), 1);
            chk("wr_wen", 32'(mem_wen), 32'(v));
            chk("wr_addr", 32'(mem_addr), 32'(a));
            chk("wr_din", 32'(mem_din), 32'(wdata[i]));
            chk("wr_done", 32'(done), 0);
            if (v) begin
                exp_mem[a] = wdata[i];
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("wr_words", 32'(i), 32'(l) + 1);
        #1;
        chk("wr_done_pulse", 32'(done), 1);
        chk("wr_done_busy", 32'(busy), 1);
        chk("wr_done_wen", 32'(mem_wen), 0);
        @(negedge clk);
        #1;
        chk_idle("wr_end");
    endtask

    task automatic do_read(input logic [AW-1:0] b, input logic [AW-1:0] l, input int stall_word,
                           input bit rnd);
        int stall;
        logic [AW-1:0] a;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; base_addr = b; len = l;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            a = b + AW'(i);
            #1;
            chk("rd_req_addr", 32'(mem_addr), 32'(a));
            chk("rd_req_wen", 32'(mem_wen), 0);
            chk("rd_req_oval", 32'(out_valid), 0);
            chk("rd_req_inrdy", 32'(in_ready), 0);
            chk("rd_req_busy", 32'(busy), 1);
            @(negedge clk);
            #1;
            chk("rd_cap_oval", 32'(out_valid), 0);
            chk("rd_cap_wen", 32'(mem_wen), 0);
            @(negedge clk);
            stall = (i == stall_word) ? 5 : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s <= stall; s++) begin
                out_ready = (s == stall);
                #1;
                chk("rd_out_oval", 32'(out_valid), 1);
                chk("rd_out_data", 32'(out_data), 32'(exp_mem[a]));
                chk("rd_out_wen", 32'(mem_wen), 0);
                chk("rd_out_done", 32'(done), 0);
                @(negedge clk);
            end
            out_ready = 1'b0;
        end
        #1;
        chk("rd_done_pulse", 32'(done), 1);
        chk("rd_done_oval", 32'(out_valid), 0);
        @(negedge clk);
        #1;
        chk_idle("rd_end");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] b;
        logic [AW-1:0] l;
        rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk_idle("reset");
        chk("reset_odata", 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full-memory write, base 0, data 10..41, then read back
        for (int k = 0; k < int'(NW); k++) wdata[k] = DW'(10 + k);
        do_write(0, 31, 1'b0, 1'b0);
        chk_mem("fill");
        do_read(0, 31, -1, 1'b0);

        // Wrapping burst at the top of the address space
        wdata[0] = 8'hAA; wdata[1] = 8'hBB; wdata[2] = 8'hCC; wdata[3] = 8'hDD;
        do_write(30, 3, 1'b0, 1'b0);
        chk_mem("wrap");
        do_read(30, 3, -1, 1'b0);

        // Downstream stall on word 2
        do_read(0, 7, 2, 1'b0);

        // Input gaps with start pulsed mid-burst
        fill_random();
        do_write(5, 9, 1'b1, 1'b1);
        chk_mem("gaps");

        // Full-length burst from a non-zero base
        fill_random();
        do_write(17, 31, 1'b1, 1'b0);
        chk_mem("fullwrap");
        do_read(17, 31, -1, 1'b1);

        // Reset after 3 of 8 writes
        fill_random();
        b = AW'($urandom);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = b; len = 7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = wdata[i];
            exp_mem[b + AW'(i)] = wdata[i];
            @(negedge clk);
        end
        in_data = wdata[3];
        rst = 1'b1;
        #1;
        chk_idle("midrst");
        chk("midrst_odata", 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_idle("midrst_after");
        chk_mem("midrst");
        do_read(b, 2, -1, 1'b0);

        // Random bursts
        for (int r = 0; r < 6; r++) begin
            b = AW'($urandom);
            l = AW'($urandom_range(0, 12));
            if ($urandom_range(0, 1) == 0) begin
                fill_random();
                do_write(b, l, 1'b1, 1'b1);
                chk_mem("rand_wr");
            end else begin
                do_read(b, l, int'($urandom_range(0, 15)), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
